// File: rtl/frog_collision_ctrl_if.sv
// Port bundle for frog_collision_ctrl: frame/restart strobes, sprite positions in, scan and game state out.
interface frog_collision_ctrl_if;
  logic        frame_start;
  logic        restart;
  logic [9:0]  frog_x;
  logic [8:0]  frog_y;
  logic [49:0] cars_x;
  logic        has_collided;
  logic [2:0]  hit_lane;
  logic        scan_done;
  logic        frog_respawn;
  logic [2:0]  lives;
  logic        game_over;
  logic        invulnerable;
  logic        busy;
  logic        overrun;

  modport master (
    output frame_start, restart, frog_x, frog_y, cars_x,
    input  has_collided, hit_lane, scan_done, frog_respawn, lives,
           game_over, invulnerable, busy, overrun
  );

  modport slave (
    input  frame_start, restart, frog_x, frog_y, cars_x,
    output has_collided, hit_lane, scan_done, frog_respawn, lives,
           game_over, invulnerable, busy, overrun
  );
endinterface

// File: rtl/frog_collision_ctrl.sv
// Per-frame serial collision scan of five car lanes with one shared overlap comparator,
// followed by life / respawn / invulnerability / game-over bookkeeping.
module frog_collision_ctrl #(
  parameter int TILE_SIZE     = 32,
  parameter int C_LINE_1_Y    = 128,
  parameter int C_LINE_2_Y    = 160,
  parameter int C_LINE_3_Y    = 192,
  parameter int C_LINE_4_Y    = 288,
  parameter int C_LINE_5_Y    = 320,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60
) (
  input logic                  clk,
  input logic                  rst,
  frog_collision_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [10:0] TILE        = 11'(TILE_SIZE);
  localparam logic [2:0]  LIVES_INIT  = 3'(START_LIVES);
  localparam logic [7:0]  INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [2:0]  LAST_LANE   = 3'd4;

  state_t      state_r, state_s;
  logic [2:0]  lane_r;
  logic [9:0]  frog_x_r;
  logic [8:0]  frog_y_r;
  logic [49:0] cars_x_r;
  logic        hit_acc_r;
  logic [2:0]  hit_lane_acc_r;
  logic [7:0]  counter_r, counter_s;
  logic        has_collided_r, scan_done_r, frog_respawn_r, game_over_r;
  logic        invulnerable_r, busy_r, overrun_r;
  logic [2:0]  hit_lane_r, lives_r;
  logic        accept_s, overrun_evt_s, lane_hit_s, penalize_s;

  function automatic logic [10:0] lane_top(input logic [2:0] k);
    case (k)
      3'd0:    lane_top = 11'(C_LINE_1_Y);
      3'd1:    lane_top = 11'(C_LINE_2_Y);
      3'd2:    lane_top = 11'(C_LINE_3_Y);
      3'd3:    lane_top = 11'(C_LINE_4_Y);
      3'd4:    lane_top = 11'(C_LINE_5_Y);
      default: lane_top = 11'd0;
    endcase
  endfunction

  // 11-bit sums so a car near the right edge never wraps back onto x=0
  function automatic logic lane_overlap(input logic [2:0] k, input logic [9:0] fx,
                                        input logic [8:0] fy, input logic [49:0] cars);
    logic [10:0] xf, xc, yf, yl;
    xf = {1'b0, fx};
    xc = {1'b0, cars[int'(k) * 10 +: 10]};
    yf = {2'b00, fy};
    yl = lane_top(k);
    lane_overlap = (xf < xc + TILE) && (xc < xf + TILE) && (yf >= yl) && (yf < yl + TILE);
  endfunction

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    if (bus.restart) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = (bus.frame_start && !game_over_r) ? SCAN : IDLE;
        SCAN:    state_s = (lane_r == LAST_LANE) ? DONE : SCAN;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // control strobes and next invulnerability count
  always_comb begin
    accept_s      = 1'b0;
    overrun_evt_s = 1'b0;
    lane_hit_s    = 1'b0;
    penalize_s    = 1'b0;
    counter_s     = counter_r;
    if (!bus.restart) begin
      case (state_r)
        IDLE:    accept_s      = bus.frame_start && !game_over_r;
        SCAN: begin
          overrun_evt_s = bus.frame_start;
          lane_hit_s    = lane_overlap(lane_r, frog_x_r, frog_y_r, cars_x_r);
        end
        DONE: begin
          overrun_evt_s = bus.frame_start;
          penalize_s    = hit_acc_r && (counter_r == 8'd0);
        end
        default: accept_s = 1'b0;
      endcase
    end else begin
      accept_s = 1'b0;
    end
    if (bus.restart) begin
      counter_s = 8'd0;
    end else if (accept_s && (counter_r != 8'd0)) begin
      counter_s = counter_r - 8'd1;
    end else if (penalize_s && (lives_r > 3'd1)) begin
      counter_s = INVULN_INIT;
    end else begin
      counter_s = counter_r;
    end
  end

  // snapshot, lane accumulation and game-state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_r         <= 3'd0;
      frog_x_r       <= 10'd0;
      frog_y_r       <= 9'd0;
      cars_x_r       <= 50'd0;
      hit_acc_r      <= 1'b0;
      hit_lane_acc_r <= 3'd0;
      counter_r      <= 8'd0;
      has_collided_r <= 1'b0;
      hit_lane_r     <= 3'd0;
      scan_done_r    <= 1'b0;
      frog_respawn_r <= 1'b0;
      lives_r        <= LIVES_INIT;
      game_over_r    <= 1'b0;
      invulnerable_r <= 1'b0;
      busy_r         <= 1'b0;
    end else if (bus.restart) begin
      lane_r         <= 3'd0;
      hit_acc_r      <= 1'b0;
      hit_lane_acc_r <= 3'd0;
      counter_r      <= 8'd0;
      has_collided_r <= 1'b0;
      hit_lane_r     <= 3'd0;
      scan_done_r    <= 1'b0;
      frog_respawn_r <= 1'b0;
      lives_r        <= LIVES_INIT;
      game_over_r    <= 1'b0;
      invulnerable_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      counter_r      <= counter_s;
      invulnerable_r <= (counter_s != 8'd0);
      busy_r         <= (state_s != IDLE);
      scan_done_r    <= (state_r == DONE);
      frog_respawn_r <= 1'b0;
      if (accept_s) begin
        frog_x_r       <= bus.frog_x;
        frog_y_r       <= bus.frog_y;
        cars_x_r       <= bus.cars_x;
        lane_r         <= 3'd0;
        hit_acc_r      <= 1'b0;
        hit_lane_acc_r <= 3'd0;
      end else if (state_r == SCAN) begin
        lane_r <= lane_r + 3'd1;
        if (lane_hit_s && !hit_acc_r) begin
          hit_acc_r      <= 1'b1;
          hit_lane_acc_r <= lane_r;
        end
      end else if (state_r == DONE) begin
        has_collided_r <= hit_acc_r;
        hit_lane_r     <= hit_lane_acc_r;
        if (penalize_s) begin
          lives_r <= lives_r - 3'd1;
          if (lives_r > 3'd1) begin
            frog_respawn_r <= 1'b1;
          end else begin
            game_over_r <= 1'b1;
          end
        end
      end
    end
  end

  // sticky overrun flag, cleared only by the hard reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (overrun_evt_s) begin
      overrun_r <= 1'b1;
    end
  end

  assign bus.has_collided = has_collided_r;
  assign bus.hit_lane     = hit_lane_r;
  assign bus.scan_done    = scan_done_r;
  assign bus.frog_respawn = frog_respawn_r;
  assign bus.lives        = lives_r;
  assign bus.game_over    = game_over_r;
  assign bus.invulnerable = invulnerable_r;
  assign bus.busy         = busy_r;
  assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Self-checking bench: boundary vector table, hand-written multi-cycle sequences and a
// randomized run, all compared every cycle against a frame-level reference model.
module tb_frog_collision_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  frog_collision_ctrl_if bus ();

  frog_collision_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // reference model state
  int m_lives, m_cnt, m_busy_cnt, m_pend_lane, m_hl;
  bit m_go, m_hc, m_sd, m_resp, m_ovr, m_pend_hit;

  function automatic int lane_top_m(int k);
    case (k)
      0:       return 128;
      1:       return 160;
      2:       return 192;
      3:       return 288;
      default: return 320;
    endcase
  endfunction

  task automatic model_reset();
    m_lives = 3; m_cnt = 0; m_busy_cnt = 0; m_go = 0; m_hc = 0; m_hl = 0;
    m_sd = 0; m_resp = 0; m_ovr = 0;
  endtask

  task automatic model_scan(output bit hit, output int lane);
    int fx, fy, cx, ly;
    hit = 0; lane = 0;
    fx = int'(bus.frog_x); fy = int'(bus.frog_y);
    for (int k = 0; k < 5; k++) begin
      cx = int'(bus.cars_x[k*10 +: 10]);
      ly = lane_top_m(k);
      if (!hit && fx < cx + 32 && cx < fx + 32 && fy >= ly && fy < ly + 32) begin
        hit = 1; lane = k;
      end
    end
  endtask

  task automatic model_edge(input bit fs, input bit rs);
    m_sd = 0; m_resp = 0;
    if (rst) begin
      model_reset();
    end else if (rs) begin
      m_lives = 3; m_go = 0; m_cnt = 0; m_hc = 0; m_hl = 0; m_busy_cnt = 0;
    end else if (m_busy_cnt > 0) begin
      if (fs) m_ovr = 1;
      m_busy_cnt--;
      if (m_busy_cnt == 0) begin
        m_hc = m_pend_hit; m_hl = m_pend_lane; m_sd = 1;
        if (m_pend_hit && m_cnt == 0) begin
          m_lives--;
          if (m_lives > 0) begin
            m_resp = 1; m_cnt = 60;
          end else begin
            m_go = 1;
          end
        end
      end
    end else if (fs && !m_go) begin
      model_scan(m_pend_hit, m_pend_lane);
      if (m_cnt > 0) m_cnt--;
      m_busy_cnt = 6;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("has_collided", int'(bus.has_collided), int'(m_hc));
    chk("hit_lane", int'(bus.hit_lane), m_hl);
    chk("scan_done", int'(bus.scan_done), int'(m_sd));
    chk("frog_respawn", int'(bus.frog_respawn), int'(m_resp));
    chk("lives", int'(bus.lives), m_lives);
    chk("game_over", int'(bus.game_over), int'(m_go));
    chk("invulnerable", int'(bus.invulnerable), int'(m_cnt != 0));
    chk("busy", int'(bus.busy), int'(m_busy_cnt > 0));
    chk("overrun", int'(bus.overrun), int'(m_ovr));
  endtask

  int sd_seen;

  task automatic step(input bit fs, input bit rs);
    bus.frame_start = fs; bus.restart = rs;
    @(posedge clk);
    model_edge(fs, rs);
    #1;
    if (bus.scan_done) sd_seen++;
    compare_all();
    bus.frame_start = 1'b0; bus.restart = 1'b0;
  endtask

  task automatic set_pos(input int fx, input int fy, input int c0, input int c1,
                         input int c2, input int c3, input int c4);
    bus.frog_x = 10'(fx); bus.frog_y = 9'(fy);
    bus.cars_x = {10'(c4), 10'(c3), 10'(c2), 10'(c1), 10'(c0)};
  endtask

  task automatic run_frame(input int gap);
    step(1'b1, 1'b0);
    for (int i = 1; i < gap; i++) step(1'b0, 1'b0);
  endtask

  typedef struct {
    int fx; int fy; int car0; int car1; int car3;
    int exp_hit; int exp_lane; int exp_lives;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{122, 160, 600, 90,   600, 0, 0, 3};
    vecs[1] = '{121, 160, 600, 90,   600, 1, 1, 2};
    vecs[2] = '{58,  160, 600, 90,   600, 0, 0, 3};
    vecs[3] = '{59,  160, 600, 90,   600, 1, 1, 2};
    vecs[4] = '{100, 191, 600, 90,   600, 1, 1, 2};
    vecs[5] = '{100, 192, 600, 90,   600, 0, 0, 3};
    vecs[6] = '{0,   160, 600, 1010, 600, 0, 0, 3};
    vecs[7] = '{100, 288, 100, 600,  100, 1, 3, 2};

    bus.frame_start = 1'b0; bus.restart = 1'b0;
    set_pos(0, 0, 600, 600, 600, 600, 600);
    model_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    chk("reset_lives", int'(bus.lives), 3);
    chk("reset_busy", int'(bus.busy), 0);

    // boundary table
    foreach (vecs[i]) begin
      step(1'b0, 1'b1);
      set_pos(vecs[i].fx, vecs[i].fy, vecs[i].car0, vecs[i].car1, 600, vecs[i].car3, 600);
      step(1'b1, 1'b0);
      for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
      chk($sformatf("vec%0d_scan_done", i), int'(bus.scan_done), 1);
      chk($sformatf("vec%0d_hit", i), int'(bus.has_collided), vecs[i].exp_hit);
      chk($sformatf("vec%0d_lane", i), int'(bus.hit_lane), vecs[i].exp_lane);
      chk($sformatf("vec%0d_lives", i), int'(bus.lives), vecs[i].exp_lives);
      step(1'b0, 1'b0);
    end

    // first hit, protected second frame, then run down all lives
    step(1'b0, 1'b1);
    set_pos(100, 160, 600, 90, 600, 600, 600);
    step(1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
    chk("hit1_respawn", int'(bus.frog_respawn), 1);
    chk("hit1_lives", int'(bus.lives), 2);
    chk("hit1_invuln", int'(bus.invulnerable), 1);
    chk("hit1_lane", int'(bus.hit_lane), 1);
    step(1'b0, 1'b0);
    chk("respawn_width", int'(bus.frog_respawn), 0);
    step(1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
    chk("prot_hit", int'(bus.has_collided), 1);
    chk("prot_respawn", int'(bus.frog_respawn), 0);
    chk("prot_lives", int'(bus.lives), 2);
    for (int f = 0; f < 70; f++) run_frame(8);
    chk("hit2_lives", int'(bus.lives), 1);
    for (int f = 0; f < 70; f++) run_frame(8);
    chk("hit3_lives", int'(bus.lives), 0);
    chk("hit3_game_over", int'(bus.game_over), 1);
    step(1'b1, 1'b0);
    chk("gameover_busy", int'(bus.busy), 0);

    // overrun and restart mid-scan
    step(1'b0, 1'b1);
    set_pos(100, 160, 600, 90, 600, 600, 600);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("overrun_set", int'(bus.overrun), 1);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    chk("overrun_result", int'(bus.hit_lane), 1);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    sd_seen = 0;
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
    chk("restart_no_done", sd_seen, 0);
    chk("restart_lives", int'(bus.lives), 3);
    chk("restart_game_over", int'(bus.game_over), 0);
    chk("overrun_sticky", int'(bus.overrun), 1);

    // asynchronous reset mid-scan
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("areset_lives", int'(bus.lives), 3);
    step(1'b0, 1'b0);
    rst = 1'b0;
    sd_seen = 0;
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
    chk("areset_no_done", sd_seen, 0);

    // randomized run
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int fx, fy, base;
        fx = $urandom_range(0, 1023);
        if ($urandom_range(0, 2) == 0) begin
          fy = $urandom_range(0, 511);
        end else begin
          fy = lane_top_m($urandom_range(0, 4)) + $urandom_range(0, 40) - 8;
        end
        bus.frog_x = 10'(fx); bus.frog_y = 9'(fy);
        for (int k = 0; k < 5; k++) begin
          if ($urandom_range(0, 1) == 1) base = (fx + $urandom_range(0, 80) + 1024 - 40) % 1024;
          else base = $urandom_range(0, 1023);
          bus.cars_x[k*10 +: 10] = 10'(base);
        end
      end
      if (it == 1500) begin
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
      end else begin
        step($urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
